// File: rtl/parking_pkg.sv
// parking_pkg: shared display-mode type, blink default and LED pattern encoder
package parking_pkg;
  typedef enum logic {DISP_ONEHOT = 1'b0, DISP_BAR = 1'b1} disp_mode_t;
  localparam int DEFAULT_BLINK_DIV = 25_000_000;
  localparam int LED_MAX = 64;
  // Active-low pattern over the widest supported strip; callers truncate to their width
  function automatic logic [LED_MAX-1:0] led_encode(input int cnt, input disp_mode_t m);
    logic [LED_MAX-1:0] r;
    for (int i = 0; i < LED_MAX; i++) r[i] = (m == DISP_BAR) ? (i > cnt) : (i != cnt);
    return r;
  endfunction
endpackage

// File: rtl/blink_tick_gen.sv
// blink_tick_gen: square-wave phase for the full-lot blink, parked lit while disabled
module blink_tick_gen
  import parking_pkg::*;
#(
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase
);
  localparam int W = $clog2(BLINK_DIV);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == W'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/parking_occupancy_display.sv
// parking_occupancy_display: sensor-edge occupancy counter driving an active-low LED strip
module parking_occupancy_display
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 7,
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1),
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               car_in,
  input  logic               car_out,
  input  logic               mode,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               gate_open,
  output logic               reject,
  output logic               underflow,
  output logic [NUM_SLOTS:0] led
);
  localparam int LED_W = NUM_SLOTS + 1;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(NUM_SLOTS);
  logic in_q, out_q, armed, phase, in_ev, out_ev, go, rej, uf;
  logic [CNT_W-1:0] cnt_nxt;
  logic [LED_W-1:0] led_nxt;
  // armed masks the first cycle after reset so a sensor held high is not an edge
  assign in_ev  = armed & car_in & ~in_q;
  assign out_ev = armed & car_out & ~out_q;
  always_comb begin
    go      = in_ev & (out_ev | (count != MAX));
    rej     = in_ev & ~out_ev & (count == MAX);
    uf      = out_ev & ~in_ev & (count == '0);
    cnt_nxt = (in_ev & ~out_ev & ~rej) ? count + CNT_W'(1) :
              (out_ev & ~in_ev & ~uf)  ? count - CNT_W'(1) : count;
    led_nxt = LED_W'(led_encode(int'(count), disp_mode_t'(mode)));
    led_nxt[NUM_SLOTS] = full ? ~phase : led_nxt[NUM_SLOTS];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_q      <= 1'b0;
      out_q     <= 1'b0;
      armed     <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      gate_open <= 1'b0;
      reject    <= 1'b0;
      underflow <= 1'b0;
      led       <= {{NUM_SLOTS{1'b1}}, 1'b0};
    end else begin
      in_q      <= car_in;
      out_q     <= car_out;
      armed     <= 1'b1;
      count     <= cnt_nxt;
      full      <= (cnt_nxt == MAX);
      gate_open <= go;
      reject    <= rej;
      underflow <= uf;
      led       <= led_nxt;
    end
  blink_tick_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (full),
    .phase(phase)
  );
endmodule

// File: tb/tb_parking_occupancy_display.sv
// tb_parking_occupancy_display: scoreboard bench with a cycle model of occupancy, pulses and LEDs
module tb_parking_occupancy_display;
  localparam int N = 7;
  localparam int BD = 4;
  logic clk = 1'b0, rst = 1'b1, car_in = 1'b0, car_out = 1'b0, mode = 1'b0;
  logic [2:0] count;
  logic full, gate_open, reject, underflow;
  logic [7:0] led;
  typedef struct packed {logic [2:0] c; logic f, g, r, u; logic [7:0] l;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int m_cnt = 0, m_bc = 0;
  logic m_iq = 0, m_oq = 0, m_arm = 0, m_full = 0, m_ph = 1;

  parking_occupancy_display #(.NUM_SLOTS(N), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .car_in(car_in), .car_out(car_out), .mode(mode),
    .count(count), .full(full), .gate_open(gate_open), .reject(reject),
    .underflow(underflow), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic ci, input logic co, input logic md);
    exp_t e;
    logic ie, oe;
    logic [7:0] l;
    car_in = ci; car_out = co; mode = md;
    e = '0;
    l = md ? (8'hFF << (m_cnt + 1)) : ~(8'h01 << m_cnt);
    if (m_full) l[7] = ~m_ph;
    if (!m_full) begin m_bc = 0; m_ph = 1; end
    else if (m_bc == BD - 1) begin m_bc = 0; m_ph = ~m_ph; end
    else m_bc++;
    ie = m_arm & ci & ~m_iq;
    oe = m_arm & co & ~m_oq;
    if (ie && !oe) begin
      if (m_cnt < N) begin m_cnt++; e.g = 1; end else e.r = 1;
    end else if (oe && !ie) begin
      if (m_cnt > 0) m_cnt--; else e.u = 1;
    end else if (ie && oe) e.g = 1;
    m_full = (m_cnt == N);
    m_iq = ci; m_oq = co; m_arm = 1;
    e.c = 3'(m_cnt); e.f = m_full; e.l = l;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("count", count, e.c);
    chk("full", full, e.f);
    chk("gate_open", gate_open, e.g);
    chk("reject", reject, e.r);
    chk("underflow", underflow, e.u);
    chk("led", led, e.l);
  endtask

  task automatic pulse(input logic ci, input logic co, input logic md);
    cyc(ci, co, md);
    cyc(0, 0, md);
  endtask

  task automatic do_reset(input logic ci);
    @(posedge clk); #1;
    rst = 1; car_in = ci; car_out = 0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_led", led, 8'hFE);
    chk("rst_pulses", {gate_open, reject, underflow}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    m_cnt = 0; m_bc = 0; m_iq = 0; m_oq = 0; m_arm = 0; m_full = 0; m_ph = 1;
  endtask

  initial begin
    do_reset(1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("held_high_count", count, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < N; i++) pulse(1, 0, 0);
    chk("full_count", count, 7);
    chk("full_flag", full, 1);
    chk("full_led", led, 8'h7F);
    pulse(1, 0, 0);
    chk("reject_hold", count, 7);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    pulse(1, 1, 0);
    chk("both_full_count", count, 7);
    for (int i = 0; i < N; i++) pulse(0, 1, 0);
    chk("empty_count", count, 0);
    pulse(1, 1, 0);
    chk("both_empty_count", count, 0);
    pulse(0, 1, 0);
    for (int i = 0; i < 3; i++) pulse(1, 0, 0);
    cyc(0, 0, 1);
    chk("bar3_led", led, 8'hF0);
    cyc(0, 0, 0);
    chk("onehot3_led", led, 8'hF7);
    for (int i = 0; i < 4; i++) pulse(1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    do_reset(0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("rearm_count", count, 1);
    cyc(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
